// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter
//   Two-requester round-robin arbiter that owns the select line of a shared
//   2x1 multiplexer bank. Grants are exclusive and multi-cycle; a grant held
//   for TIMEOUT cycles is force-released. All outputs come straight from
//   registers, so the mux select never glitches mid-transaction.
//
// Parameters
//   TIMEOUT     maximum cycles a single grant may be held (1 .. 2^CW-1)
//   CW          width of the hold counter
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   req[1:0]    req[i] high: requester i wants the shared path
//   done[1:0]   done[i] high: requester i is finished (owner's bit only)
//   gnt[1:0]    registered one-hot-or-zero ownership
//   sel         registered mux select, index of current or most recent owner
//   busy        high while any grant is active
//   timeout_err one-cycle pulse after a grant is force-released

module mux_share_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  localparam logic [CW-1:0] CntMax = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          terr_q, terr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  logic pick_valid;
  logic pick_idx;
  logic own;
  logic hit_max;
  logic rel;
  logic arb;

  // While owning, last_q already equals the owner, so a tie on release goes
  // to the other requester without a separate pointer update.
  assign pick_valid = |req;
  assign pick_idx   = (req == 2'b11) ? ~last_q : req[1];

  assign own     = (state_q == StOwn1);
  assign hit_max = (cnt_q == CntMax);
  assign rel     = done[own] | ~req[own] | hit_max;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    terr_d  = 1'b0;
    arb     = 1'b0;

    unique case (state_q)
      StIdle: arb = 1'b1;
      StOwn0, StOwn1: begin
        if (rel) begin
          arb = 1'b1;
          // Error only when the counter alone forced the release.
          terr_d = hit_max & ~done[own] & req[own];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: arb = 1'b1;
    endcase

    if (arb) begin
      cnt_d = '0;
      if (pick_valid) begin
        state_d = pick_idx ? StOwn1 : StOwn0;
        gnt_d   = pick_idx ? 2'b10 : 2'b01;
        sel_d   = pick_idx;
        last_d  = pick_idx;
      end else begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    end

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= 2'b00;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign gnt         = gnt_q;
  assign sel         = sel_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed testbench for mux_share_arbiter with TIMEOUT=4. Outputs are
// observed as the packed vector {gnt, sel, busy, timeout_err}.

module tb_mux_share_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [1:0] done;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;
  logic       timeout_err;

  int n_cmp;
  int n_err;

  mux_share_arbiter #(
    .TIMEOUT(4),
    .CW     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .gnt        (gnt),
    .sel        (sel),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [4:0] obs = {gnt, sel, busy, timeout_err};

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00; done = 2'b00;
    step(); step();
    n_cmp++;
    if (obs !== 5'b00_0_0_0) begin
      n_err++; $display("FAIL reset_values: got %b want %b", obs, 5'b00000);
    end
    reset = 1'b0;
    req = 2'b10;
    step();
    n_cmp++;
    if (obs !== 5'b10_1_1_0) begin
      n_err++; $display("FAIL own1_before_reset: got %b want %b", obs, 5'b10110);
    end
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 5'b00_0_0_0) begin
      n_err++; $display("FAIL async_reset: got %b want %b", obs, 5'b00000);
    end
    #1 reset = 1'b0;
    req = 2'b11;
    step();
    n_cmp++;
    if (obs !== 5'b01_0_1_0) begin
      n_err++; $display("FAIL first_tie_after_reset: got %b want %b", obs, 5'b01010);
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_single();
    req = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      step();
      n_cmp++;
      if (obs !== 5'b10_1_1_0) begin
        n_err++; $display("FAIL single_own cycle %0d: got %b want %b", c, obs, 5'b10110);
      end
    end
    done = 2'b10; req = 2'b00;
    step();
    done = 2'b00;
    n_cmp++;
    if (obs !== 5'b00_1_0_0) begin
      n_err++; $display("FAIL single_release_sel_holds: got %b want %b", obs, 5'b00100);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    req = 2'b11;
    step();
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (obs !== {exp, exp[1], 2'b10}) begin
        n_err++; $display("FAIL rr_grant %0d first: got %b want %b", k, obs, {exp, exp[1], 2'b10});
      end
      step();
      n_cmp++;
      if (obs !== {exp, exp[1], 2'b10}) begin
        n_err++; $display("FAIL rr_grant %0d second: got %b want %b", k, obs, {exp, exp[1], 2'b10});
      end
      done = exp;
      step();
      done = 2'b00;
    end
    n_cmp++;
    if (obs !== 5'b01_0_1_0) begin
      n_err++; $display("FAIL rr_fifth_grant: got %b want %b", obs, 5'b01010);
    end
    req = 2'b00;
    step();
    n_cmp++;
    if (obs !== 5'b00_0_0_0) begin
      n_err++; $display("FAIL rr_to_idle: got %b want %b", obs, 5'b00000);
    end
  endtask

  task automatic test_timeout();
    req = 2'b01;
    step();
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if (obs !== 5'b01_0_1_0) begin
        n_err++; $display("FAIL to_hold cycle %0d: got %b want %b", c, obs, 5'b01010);
      end
      if (c < 4) step();
    end
    step();
    n_cmp++;
    if (obs !== 5'b01_0_1_1) begin
      n_err++; $display("FAIL to_regrant_pulse: got %b want %b", obs, 5'b01011);
    end
    step();
    n_cmp++;
    if (obs !== 5'b01_0_1_0) begin
      n_err++; $display("FAIL to_pulse_one_cycle: got %b want %b", obs, 5'b01010);
    end
    req = 2'b11;
    step(); step();
    n_cmp++;
    if (obs !== 5'b01_0_1_0) begin
      n_err++; $display("FAIL to_other_waits: got %b want %b", obs, 5'b01010);
    end
    step();
    n_cmp++;
    if (obs !== 5'b10_1_1_1) begin
      n_err++; $display("FAIL to_moves_to_1: got %b want %b", obs, 5'b10111);
    end
    step();
    n_cmp++;
    if (obs !== 5'b10_1_1_0) begin
      n_err++; $display("FAIL to_after_move: got %b want %b", obs, 5'b10110);
    end
    req = 2'b00;
    step();
  endtask

  task automatic test_foreign_done();
    req = 2'b01;
    step();
    done = 2'b10;
    step();
    done = 2'b00;
    n_cmp++;
    if (obs !== 5'b01_0_1_0) begin
      n_err++; $display("FAIL foreign_done_ignored: got %b want %b", obs, 5'b01010);
    end
    req = 2'b00;
    step();
    n_cmp++;
    if (obs !== 5'b00_0_0_0) begin
      n_err++; $display("FAIL drop_req_release: got %b want %b", obs, 5'b00000);
    end
  endtask

  task automatic test_done_at_timeout();
    req = 2'b01;
    step(); step(); step(); step();
    done = 2'b01;
    step();
    done = 2'b00;
    n_cmp++;
    if (obs !== 5'b01_0_1_0) begin
      n_err++; $display("FAIL done_at_timeout_no_err: got %b want %b", obs, 5'b01010);
    end
    step();
    n_cmp++;
    if (obs !== 5'b01_0_1_0) begin
      n_err++; $display("FAIL done_at_timeout_next: got %b want %b", obs, 5'b01010);
    end
    req = 2'b00;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_foreign_done();
    test_done_at_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
